gates_bist: RTL and testbench
=============================

# gates_bist

Self-checking stimulus/response engine for the simple-gate library, and the on-chip counterpart of the external C testbench. The external C testbench drives the gate inputs and checks the outputs from software; this block does both jobs in RTL. It generates pseudo-random operand vectors with LFSRs, drives them into the Inv/And2/Nand2/Mux2/Nor2/Maj3 instances, and compares every gate output against an internal behavioral model. It reports pass/fail, an error count and the first failing vector index, so gate regressions can run in simulation or silicon without a host.

## Interface
Parameters:
- WIDTH, 64, operand width; must be 64 (LFSR polynomial is fixed for 64 bits).
- NUM_VECTORS, 256, vectors per run; range 1..2^20-1.
- SEED, 64'h0123_4567_89AB_CDEF, base LFSR seed.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin run; sampled in IDLE or DONE only.
- abort  in  1  stop run; return to IDLE.
- in1, in2, in3  out  WIDTH  operands to gate instances (LFSR registers).
- out_inv, out_and2, out_nand2, out_mux2, out_nor2, out_maj3  in  WIDTH  gate responses (combinational from in1..in3).
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- pass  out  1  done && err_count==0.
- err_count  out  16  vectors with ≥1 mismatching gate, saturating.
- first_fail  out  20  index of first failing vector; valid when err_count!=0.
- signature  out  64  MISR signature (see Configuration).

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE --start--> RUN.
  - RUN --(vec_idx==NUM_VECTORS-1)--> DONE.
  - RUN --abort--> IDLE.
  - DONE --start--> RUN.
  - DONE --abort--> IDLE.
  - abort has priority over start and over the last-vector transition.
- Seeds: LFSR1=SEED, LFSR2=~SEED, LFSR3=SEED^64'hA5A5_A5A5_5A5A_5A5A. A seed that evaluates to 0 is replaced with 64'h1.
- LFSR step (Fibonacci): next = {s[62:0], s[63]^s[62]^s[60]^s[59]}.
- Seeds are loaded on reset and on every accepted start. LFSRs advance once per RUN cycle and hold otherwise.
- Expected model, with a=in1, b=in2, c=in3:
  - inv = ~a
  - and2 = a&b
  - nand2 = ~(a&b)
  - nor2 = ~(a|b)
  - mux2 = c[0] ? b : a
  - maj3 = (a&b)|(a&c)|(b&c)
- A vector fails if any bit of any of the six outputs differs from the model.
- Each failure increments err_count by 1, saturating at 16'hFFFF.
- On the first failure of a run (err_count==0), first_fail is captured as vec_idx.
- An accepted start clears err_count, first_fail, vec_idx and signature.
- start while busy is ignored. abort in IDLE has no effect.

## Timing
- Reset values:
  - state=IDLE; busy=done=pass=0; err_count=0; first_fail=0; signature=0; vec_idx=0.
  - in1/in2/in3 = their seeds.
- Cycle 0 is the cycle start=1 is sampled in IDLE. Cycles 1..NUM_VECTORS are RUN: busy=1, vector k is on in1..in3 in cycle k+1.
- Compare is same-cycle against combinational DUT outputs. err_count/first_fail update on the edge that ends the cycle.
- done rises in cycle NUM_VECTORS+1, with final err_count and pass valid in that same cycle. done holds until start, abort or rst.
- Run latency: NUM_VECTORS+1 cycles from start to done.
- Abort in RUN: busy=0 from the next cycle; done stays 0; counters hold partial values; LFSRs hold.
- rst asserted mid-run: all outputs take reset values immediately (asynchronous). No run resumes after rst deasserts.
- NUM_VECTORS=1: a single RUN cycle, then DONE.

## Configuration
- GATES_BIST_MISR_EN defined:
  - A 64-bit MISR (same polynomial as the LFSRs) absorbs out_inv^out_and2^out_nand2^out_mux2^out_nor2^out_maj3 once per RUN cycle: sig <= step(sig) ^ data.
  - signature holds its value in IDLE/DONE; start clears it.
- GATES_BIST_MISR_EN undefined: no MISR logic; signature is tied to 64'h0.

## Test plan
- NUM_VECTORS=4, correct gates, start pulse: busy high exactly 4 cycles, then done=1, pass=1, err_count=0, in1 sequence starting at SEED.
- NUM_VECTORS=16, bench forces out_and2[5]=1: err_count equals the number of vectors with in1[5]&in2[5]==0; first_fail = first such index; pass=0.
- NUM_VECTORS=100, abort in the 10th RUN cycle: busy=0 next cycle, done=0; a new start returns in1=SEED and completes with pass=1 after 101 cycles.
- start re-pulsed during RUN: ignored, done arrives at the original cycle. rst asserted at RUN cycle 3: all outputs return to reset values without waiting for a clock edge.
- NUM_VECTORS=70000, out_inv forced to in1: err_count saturates at 16'hFFFF; first_fail=0.
- GATES_BIST_MISR_EN defined, NUM_VECTORS=8, two runs with identical seeds: identical nonzero signature. Flipping one DUT output bit changes the signature. Without the macro, signature=0.

Source files
------------

// File: rtl/gates_bist.sv
// gates_bist: on-chip stimulus/response engine for the simple-gate library.
// Three LFSRs drive pseudo-random operands into the gate instances.
// Every returned gate output is compared against a behavioural model in the same cycle.
// The block reports pass/fail, a saturating error count and the first failing vector index.
// Optional feature macro: GATES_BIST_MISR_EN.
//   Defined:   a 64-bit MISR compacts the XOR of all six gate outputs once per RUN cycle.
//   Undefined: there is no MISR and signature is tied to zero.
module gates_bist #(
   parameter int          WIDTH       = 64,
   parameter int          NUM_VECTORS = 256,
   parameter logic [63:0] SEED        = 64'h0123_4567_89AB_CDEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   output logic [WIDTH-1:0] in1,
   output logic [WIDTH-1:0] in2,
   output logic [WIDTH-1:0] in3,
   input  logic [WIDTH-1:0] out_inv,
   input  logic [WIDTH-1:0] out_and2,
   input  logic [WIDTH-1:0] out_nand2,
   input  logic [WIDTH-1:0] out_mux2,
   input  logic [WIDTH-1:0] out_nor2,
   input  logic [WIDTH-1:0] out_maj3,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [15:0]      err_count,
   output logic [19:0]      first_fail,
   output logic [63:0]      signature
);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;

   // An all-zero seed would lock the LFSR, so it is replaced by 1.
   function automatic logic [WIDTH-1:0] fix_seed(input logic [WIDTH-1:0] s);
      return (s == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : s;
   endfunction

   // Fibonacci step shared by the operand LFSRs and the MISR.
   function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
      return {s[WIDTH-2:0], s[WIDTH-1] ^ s[WIDTH-2] ^ s[WIDTH-4] ^ s[WIDTH-5]};
   endfunction

   localparam logic [WIDTH-1:0] SEED1 = fix_seed(SEED);
   localparam logic [WIDTH-1:0] SEED2 = fix_seed(~SEED);
   localparam logic [WIDTH-1:0] SEED3 = fix_seed(SEED ^ 64'hA5A5_A5A5_5A5A_5A5A);
   localparam logic [19:0]      LAST_IDX = 20'(NUM_VECTORS - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] lfsr1_q, lfsr1_d;
   logic [WIDTH-1:0] lfsr2_q, lfsr2_d;
   logic [WIDTH-1:0] lfsr3_q, lfsr3_d;
   logic [19:0]      vec_idx_q, vec_idx_d;
   logic [15:0]      err_q, err_d;
   logic [19:0]      ff_q, ff_d;
   logic             start_acc;
   logic             last_vec;
   logic             vec_fail;

   // Start is honoured only when not running, and abort always wins over it.
   assign start_acc = (state_q != ST_RUN) && start && !abort;
   assign last_vec  = (vec_idx_q == LAST_IDX);

   // Same-cycle comparison of every gate response against the reference model.
   always_comb begin
      vec_fail = (out_inv   !== ~lfsr1_q)
              || (out_and2  !== (lfsr1_q & lfsr2_q))
              || (out_nand2 !== ~(lfsr1_q & lfsr2_q))
              || (out_nor2  !== ~(lfsr1_q | lfsr2_q))
              || (out_mux2  !== (lfsr3_q[0] ? lfsr2_q : lfsr1_q))
              || (out_maj3  !== ((lfsr1_q & lfsr2_q) | (lfsr1_q & lfsr3_q) | (lfsr2_q & lfsr3_q)));
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // FSM next state; abort has priority over start and over the last-vector exit.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start_acc) state_d = ST_RUN;
         ST_RUN: begin
            if (abort)         state_d = ST_IDLE;
            else if (last_vec) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (abort)          state_d = ST_IDLE;
            else if (start_acc) state_d = ST_RUN;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      busy = (state_q == ST_RUN);
      done = (state_q == ST_DONE);
      pass = (state_q == ST_DONE) && (err_q == 16'd0);
   end

   // Operand, index and error bookkeeping: reload on start, advance in RUN, hold otherwise.
   always_comb begin
      lfsr1_d   = lfsr1_q;
      lfsr2_d   = lfsr2_q;
      lfsr3_d   = lfsr3_q;
      vec_idx_d = vec_idx_q;
      err_d     = err_q;
      ff_d      = ff_q;
      if (start_acc) begin
         lfsr1_d   = SEED1;
         lfsr2_d   = SEED2;
         lfsr3_d   = SEED3;
         vec_idx_d = 20'd0;
         err_d     = 16'd0;
         ff_d      = 20'd0;
      end else if (state_q == ST_RUN) begin
         lfsr1_d = lfsr_step(lfsr1_q);
         lfsr2_d = lfsr_step(lfsr2_q);
         lfsr3_d = lfsr_step(lfsr3_q);
         if (!last_vec) vec_idx_d = vec_idx_q + 20'd1;
         if (vec_fail) begin
            if (err_q == 16'd0)     ff_d  = vec_idx_q;
            if (err_q != 16'hFFFF)  err_d = err_q + 16'd1;
         end
      end
   end

   // Datapath registers; operands come out of reset holding their seeds.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr1_q   <= SEED1;
         lfsr2_q   <= SEED2;
         lfsr3_q   <= SEED3;
         vec_idx_q <= 20'd0;
         err_q     <= 16'd0;
         ff_q      <= 20'd0;
      end else begin
         lfsr1_q   <= lfsr1_d;
         lfsr2_q   <= lfsr2_d;
         lfsr3_q   <= lfsr3_d;
         vec_idx_q <= vec_idx_d;
         err_q     <= err_d;
         ff_q      <= ff_d;
      end
   end

   assign in1        = lfsr1_q;
   assign in2        = lfsr2_q;
   assign in3        = lfsr3_q;
   assign err_count  = err_q;
   assign first_fail = ff_q;

`ifdef GATES_BIST_MISR_EN
   logic [63:0] sig_q, sig_d;

   // MISR next value: cleared on start, absorbs the XOR of all responses while running.
   always_comb begin
      sig_d = sig_q;
      if (start_acc)
         sig_d = 64'd0;
      else if (state_q == ST_RUN)
         sig_d = lfsr_step(sig_q) ^ out_inv ^ out_and2 ^ out_nand2 ^ out_mux2 ^ out_nor2 ^ out_maj3;
   end

   // MISR register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sig_q <= 64'd0;
      else     sig_q <= sig_d;
   end

   assign signature = sig_q;
`else
   assign signature = 64'd0;
`endif

endmodule

// File: tb/tb_gates_bist.sv
// Self-checking bench for gates_bist.
// The bench models the gate instances, with optional fault injection.
// It also keeps a reference model of the operand sequence and the expected error results.
// Optional feature macro: GATES_BIST_MISR_EN (the signature checks follow it).
module tb_gates_bist;
   localparam int          NV_A = 16;
   localparam int          NV_B = 70000;
   localparam logic [63:0] SEED = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] S1   = SEED;
   localparam logic [63:0] S2   = ~SEED;
   localparam logic [63:0] S3   = SEED ^ 64'hA5A5_A5A5_5A5A_5A5A;

   logic        clk = 1'b0;
   logic        rst, start, abort, b_start;
   int          mode;  // 0 = correct gates, 1 = and2 bit 5 stuck at 1
   int          checks = 0;
   int          failures = 0;

   logic [63:0] in1, in2, in3, o_inv, o_and2, o_nand2, o_mux2, o_nor2, o_maj3;
   logic        busy, done, pass;
   logic [15:0] err_count;
   logic [19:0] first_fail;
   logic [63:0] signature;

   logic [63:0] b_in1, b_in2, b_in3, b_inv, b_and2, b_nand2, b_mux2, b_nor2, b_maj3;
   logic        b_busy, b_done, b_pass;
   logic [15:0] b_err;
   logic [19:0] b_ff;
   logic [63:0] b_sig;

   always #5 clk = ~clk;

   // Gate library stand-ins for DUT A, with optional fault.
   assign o_inv   = ~in1;
   assign o_and2  = (in1 & in2) | ((mode == 1) ? 64'h20 : 64'h0);
   assign o_nand2 = ~(in1 & in2);
   assign o_mux2  = in3[0] ? in2 : in1;
   assign o_nor2  = ~(in1 | in2);
   assign o_maj3  = (in1 & in2) | (in1 & in3) | (in2 & in3);

   // Gate stand-ins for DUT B: the inverter is broken (passes in1 through).
   assign b_inv   = b_in1;
   assign b_and2  = b_in1 & b_in2;
   assign b_nand2 = ~(b_in1 & b_in2);
   assign b_mux2  = b_in3[0] ? b_in2 : b_in1;
   assign b_nor2  = ~(b_in1 | b_in2);
   assign b_maj3  = (b_in1 & b_in2) | (b_in1 & b_in3) | (b_in2 & b_in3);

   gates_bist #(.WIDTH(64), .NUM_VECTORS(NV_A), .SEED(SEED)) dut_a (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .in1(in1), .in2(in2), .in3(in3),
      .out_inv(o_inv), .out_and2(o_and2), .out_nand2(o_nand2),
      .out_mux2(o_mux2), .out_nor2(o_nor2), .out_maj3(o_maj3),
      .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .first_fail(first_fail), .signature(signature));

   gates_bist #(.WIDTH(64), .NUM_VECTORS(NV_B), .SEED(SEED)) dut_b (
      .clk(clk), .rst(rst), .start(b_start), .abort(1'b0),
      .in1(b_in1), .in2(b_in2), .in3(b_in3),
      .out_inv(b_inv), .out_and2(b_and2), .out_nand2(b_nand2),
      .out_mux2(b_mux2), .out_nor2(b_nor2), .out_maj3(b_maj3),
      .busy(b_busy), .done(b_done), .pass(b_pass),
      .err_count(b_err), .first_fail(b_ff), .signature(b_sig));

   function automatic logic [63:0] step(input logic [63:0] s);
      return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete run on DUT A, checked vector by vector against the model.
   task automatic do_run(input int m, input bit repulse);
      logic [63:0] a, b, c, sig, data, and_exp;
      int errs, ff;
      mode = m;
      a = S1; b = S2; c = S3; sig = '0; errs = 0; ff = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < NV_A; k++) begin
         chk("busy_run", {63'd0, busy}, 64'd1);
         chk("in1", in1, a);
         chk("in2", in2, b);
         chk("in3", in3, c);
         and_exp = (a & b) | ((m == 1) ? 64'h20 : 64'h0);
         if ((a[5] & b[5]) == 1'b0 && m == 1) begin
            if (errs == 0) ff = k;
            errs++;
         end
         data = ~a ^ and_exp ^ ~(a & b) ^ (c[0] ? b : a) ^ ~(a | b) ^ ((a & b) | (a & c) | (b & c));
         sig = step(sig) ^ data;
         a = step(a); b = step(b); c = step(c);
         if (repulse && k == 5) start = 1'b1;
         tick();
         start = 1'b0;
      end
      chk("busy_end", {63'd0, busy}, 64'd0);
      chk("done_end", {63'd0, done}, 64'd1);
      chk("err_count", {48'd0, err_count}, 64'(errs));
      if (errs != 0) chk("first_fail", {44'd0, first_fail}, 64'(ff));
      chk("pass", {63'd0, pass}, (errs == 0) ? 64'd1 : 64'd0);
`ifdef GATES_BIST_MISR_EN
      chk("signature", signature, sig);
`else
      chk("signature_off", signature, 64'd0);
`endif
      $display("run mode=%0d repulse=%0d err_count=%0d first_fail=%0d pass=%0d",
               m, repulse, err_count, first_fail, pass);
   endtask

   initial begin
      int waited;
      rst = 1'b1; start = 1'b0; abort = 1'b0; b_start = 1'b0; mode = 0;
      #3;
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_in1", in1, S1);
      chk("rst_in2", in2, S2);
      chk("rst_in3", in3, S3);
      tick();
      rst = 1'b0;
      tick();
      chk("idle_err", {48'd0, err_count}, 64'd0);
      chk("idle_pass", {63'd0, pass}, 64'd0);
      abort = 1'b1;  // abort in IDLE: no effect
      tick();
      abort = 1'b0;
      chk("idle_abort_busy", {63'd0, busy}, 64'd0);

      do_run(0, 1'b0);   // clean run from IDLE
      do_run(1, 1'b0);   // injected and2 fault, start from DONE
      do_run(0, 1'b1);   // start re-pulsed mid-run is ignored
      do_run(0, 1'b0);   // identical seeds, identical signature

      // Abort in the 10th RUN cycle, then a fresh run.
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 9; k++) tick();
      chk("pre_abort_busy", {63'd0, busy}, 64'd1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_busy", {63'd0, busy}, 64'd0);
      chk("abort_done", {63'd0, done}, 64'd0);
      tick();
      chk("abort_idle_done", {63'd0, done}, 64'd0);
      $display("abort in RUN cycle 10 -> idle");
      do_run(0, 1'b0);

      // Asynchronous reset in RUN cycle 3 with errors already accumulating.
      mode = 1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      chk("arst_busy", {63'd0, busy}, 64'd0);
      chk("arst_err", {48'd0, err_count}, 64'd0);
      chk("arst_ff", {44'd0, first_fail}, 64'd0);
      chk("arst_sig", signature, 64'd0);
      chk("arst_in1", in1, S1);
      chk("arst_in3", in3, S3);
      tick();
      rst = 1'b0;
      mode = 0;
      tick();
      tick();
      chk("post_rst_busy", {63'd0, busy}, 64'd0);
      chk("post_rst_done", {63'd0, done}, 64'd0);
      $display("async reset mid-run -> idle, no resume");

      // Saturation run on DUT B: every vector fails.
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      chk("sat_in1_first", b_in1, S1);
      waited = 0;
      while (!b_done && waited < NV_B + 10) begin
         tick();
         waited++;
      end
      chk("sat_latency", 64'(waited), 64'(NV_B));
      chk("sat_err", {48'd0, b_err}, 64'hFFFF);
      chk("sat_ff", {44'd0, b_ff}, 64'd0);
      chk("sat_pass", {63'd0, b_pass}, 64'd0);
      $display("saturation run err_count=%0d first_fail=%0d", b_err, b_ff);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
